hiscore_ram_arbiter: RTL and testbench

//  Shares the game work-RAM port between the running CPU and the hiscore save/restore engine.
//  - Raises a pause request to the core and waits for the CPU to halt.
//  - Once halted, hands the RAM port to the hiscore side and serves single-byte strobe accesses.
//  - Returns the port to the CPU after the request drops.
//  - Sits between the hiscore engine, the pause system and the game core's RAM mux.

---
 rtl/hiscore_ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_arbiter.sv
// Hands the game work-RAM port from the CPU to the hiscore engine once the core is paused.
// Optional pause-wait timeout with abort pulse is built when HS_ARB_TIMEOUT_EN is defined.
module hiscore_ram_arbiter #(
  parameter int AW          = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          hs_req,
  input  logic          hs_stb,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_wdata,
  output logic          hs_gnt,
  output logic          hs_ack,
  output logic [7:0]    hs_rdata,
  output logic          hs_abort,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PWAIT   = 3'd1,
    SETTLE  = 3'd2,
    GRANT   = 3'd3,
    ACCESS  = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t        state;
  logic [3:0]    settle_cnt;
  logic          rd_phase;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [7:0]    acc_wdata;
  logic          we_pulse;

`ifdef HS_ARB_TIMEOUT_EN
  logic [15:0]   tcnt;
  logic          hold;
`endif

  // Handshake: a one-cycle hs_stb is accepted only in GRANT; every accepted
  // strobe yields exactly one hs_ack, strobes seen in any other state are dropped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      rd_phase   <= 1'b0;
      acc_we     <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      we_pulse   <= 1'b0;
      hs_gnt     <= 1'b0;
      hs_ack     <= 1'b0;
      hs_rdata   <= '0;
      pause_req  <= 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
      tcnt       <= '0;
      hold       <= 1'b0;
      hs_abort   <= 1'b0;
`endif
    end else begin
      hs_ack   <= 1'b0;
      we_pulse <= 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
      hs_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef HS_ARB_TIMEOUT_EN
          // After an abort the engine must drop hs_req before it is heard again.
          if (!hs_req) hold <= 1'b0;
          if (hs_req && !hold) begin
            state     <= PWAIT;
            pause_req <= 1'b1;
            tcnt      <= '0;
          end
`else
          if (hs_req) begin
            state     <= PWAIT;
            pause_req <= 1'b1;
          end
`endif
        end
        PWAIT: begin
          if (!hs_req) begin
            state <= RELEASE;
          end else if (pause_ack) begin
            state      <= SETTLE;
            settle_cnt <= 4'(SETTLE_CYC);
          end
`ifdef HS_ARB_TIMEOUT_EN
          else if (tcnt == 16'(TIMEOUT_CYC - 1)) begin
            state    <= RELEASE;
            hs_abort <= 1'b1;
            hold     <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end
        SETTLE: begin
          if (!pause_ack) begin
            state <= PWAIT;
`ifdef HS_ARB_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end else if (settle_cnt == 4'd0) begin
            state  <= GRANT;
            hs_gnt <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        GRANT: begin
          if (hs_stb) begin
            state     <= ACCESS;
            acc_we    <= hs_we;
            acc_addr  <= hs_addr;
            acc_wdata <= hs_wdata;
            we_pulse  <= hs_we;
            rd_phase  <= 1'b0;
          end else if (!hs_req) begin
            state <= RELEASE;
          end
        end
        ACCESS: begin
          // Reads spend one extra cycle waiting on the synchronous RAM output.
          if (acc_we || rd_phase) begin
            hs_ack <= 1'b1;
            if (!acc_we) hs_rdata <= ram_rdata;
            state <= hs_req ? GRANT : RELEASE;
          end else begin
            rd_phase <= 1'b1;
          end
        end
        RELEASE: begin
          hs_gnt    <= 1'b0;
          pause_req <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          hs_gnt    <= 1'b0;
          pause_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef HS_ARB_TIMEOUT_EN
  assign hs_abort = 1'b0;
`endif

  // The CPU owns the port whenever hs_gnt is low, including the cycle it falls.
  assign ram_addr  = hs_gnt ? acc_addr  : cpu_addr;
  assign ram_wdata = hs_gnt ? acc_wdata : cpu_wdata;
  assign ram_we    = hs_gnt ? we_pulse  : cpu_we;
  assign cpu_rdata = ram_rdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: vector table for the port mux, directed latency
// sequences, and randomized hiscore accesses checked against a byte-array memory model.
module tb_hiscore_ram_arbiter;
  localparam int AW = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          hs_req, hs_stb, hs_we;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_gnt, hs_ack, hs_abort;
  logic [7:0]    hs_rdata;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          pause_req, pause_ack, busy;

  hiscore_ram_arbiter #(.AW(AW), .SETTLE_CYC(4), .TIMEOUT_CYC(100)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .hs_req(hs_req), .hs_stb(hs_stb), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_gnt(hs_gnt), .hs_ack(hs_ack), .hs_rdata(hs_rdata), .hs_abort(hs_abort),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .pause_req(pause_req), .pause_ack(pause_ack), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- synchronous RAM ----------------
  logic [7:0]    mem [0:65535];
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [7:0]    preload_data = '0;

  always @(posedge clk_sys) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] model_mem [0:63];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    cyc();
    preload_en = 1'b0;
  endtask

  task automatic measure_gnt(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!hs_gnt && n < 50);
  endtask

  // One hiscore access; optionally fires a stray strobe while the access is in flight.
  task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                           input logic stray, output int lat, output logic [7:0] rd);
    hs_stb = 1'b1; hs_we = we; hs_addr = a; hs_wdata = d;
    cyc();
    hs_stb = 1'b0;
    lat = 1;
    if (stray) begin
      hs_stb = 1'b1; hs_we = ~we; hs_addr = a ^ 16'h0001; hs_wdata = ~d;
    end
    while (!hs_ack && lat < 10) begin
      cyc();
      hs_stb = 1'b0;
      lat++;
    end
    rd = hs_rdata;
  endtask

  // ---------------- mux vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          we;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_wdata;
    logic          exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic apply_vectors(input string tag);
    for (int i = 0; i < 6; i++) begin
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata; cpu_we = vecs[i].we;
      #1;
      check({tag, "_ram_addr"},  ram_addr,  vecs[i].exp_addr);
      check({tag, "_ram_wdata"}, ram_wdata, vecs[i].exp_wdata);
      check({tag, "_ram_we"},    ram_we,    vecs[i].exp_we);
      cyc();
    end
    cpu_we = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, mism, viol;
    logic [7:0] rd, e;
    logic we;
    logic [AW-1:0] a;
    logic [7:0] d;

    reset = 1'b1;
    hs_req = 0; hs_stb = 0; hs_we = 0; hs_addr = '0; hs_wdata = '0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 0; pause_ack = 0;

    vecs[0] = '{16'h8000, 8'h00, 1'b0, 16'h8000, 8'h00, 1'b0};
    vecs[1] = '{16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1};
    vecs[2] = '{16'h8AAA, 8'h55, 1'b1, 16'h8AAA, 8'h55, 1'b1};
    for (int i = 3; i < 6; i++) begin
      a = 16'($urandom_range(16'h8000, 16'hFFFF));
      d = 8'($urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      vecs[i] = '{a, d, we, a, d, we};
    end

    // Reset held: pass-through and reset outputs
    cyc();
    check("rst_gnt", hs_gnt, 0);
    check("rst_ack", hs_ack, 0);
    check("rst_abort", hs_abort, 0);
    check("rst_pause_req", pause_req, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", hs_rdata, 0);
    apply_vectors("rst");
    check("rst_cpu_rdata", cpu_rdata, ram_rdata);

    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 8'($urandom_range(0, 255));
      preload(16'(i), model_mem[i]);
    end

    reset = 1'b0;
    cyc();
    apply_vectors("idle");

    // Stray strobe while idle
    hs_stb = 1'b1; hs_we = 1'b1; hs_addr = 16'h0003; hs_wdata = 8'h77;
    cyc();
    hs_stb = 1'b0;
    viol = 0;
    repeat (3) begin
      if (hs_ack || busy || hs_gnt) viol++;
      cyc();
    end
    check("idle_stray_stb", viol, 0);

    // Request to grant: pause_ack 5 cycles after hs_req, grant 6 cycles after pause_ack
    hs_req = 1'b1;
    cyc();
    check("pwait_pause_req", pause_req, 1);
    check("pwait_busy", busy, 1);
    check("pwait_gnt", hs_gnt, 0);
    repeat (4) cyc();
    pause_ack = 1'b1;
    measure_gnt(n);
    check("gnt_latency", n, 6);

    // Write 0xA5 to 0x1234 while the CPU tries to write elsewhere
    cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hEE;
    hs_stb = 1'b1; hs_we = 1'b1; hs_addr = 16'h1234; hs_wdata = 8'hA5;
    cyc();
    hs_stb = 1'b0;
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 16'h1234);
    check("wr_ram_wdata", ram_wdata, 8'hA5);
    check("wr_ack_early", hs_ack, 0);
    cyc();
    check("wr_ack", hs_ack, 1);
    check("wr_ram_we_after", ram_we, 0);
    check("wr_mem", mem[16'h1234], 8'hA5);

    // Read 0x5A from 0x1234; CPU write to the same address must not land
    preload(16'h1234, 8'h5A);
    cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hFF;
    do_access(1'b0, 16'h1234, 8'h00, 1'b0, lat, rd);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 8'h5A);
    cyc();
    check("rd_hold", hs_rdata, 8'h5A);
    check("rd_ack_one_cycle", hs_ack, 0);
    check("rd_cpu_blocked", mem[16'h1234], 8'h5A);

    // Randomized accesses against the model
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 63));
      d  = 8'($urandom_range(0, 255));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom_range(0, 63));
      cpu_wdata = 8'($urandom_range(0, 255));
      if (!we) exp_q.push_back(model_mem[a[5:0]]);
      do_access(we, a, d, ($urandom_range(0, 3) == 0), lat, rd);
      check("rand_latency", lat, we ? 2 : 3);
      if (we) begin
        model_mem[a[5:0]] = d;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rand_rdata", rd, e);
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    cpu_we = 1'b0;
    cyc();
    mism = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== model_mem[i]) mism++;
    check("ram_image", mism, 0);

    // hs_req dropped mid-read
    hs_stb = 1'b1; hs_we = 1'b0; hs_addr = 16'h0005;
    cyc();
    hs_stb = 1'b0; hs_req = 1'b0;
    cyc();
    check("drop_ack_early", hs_ack, 0);
    cyc();
    check("drop_ack", hs_ack, 1);
    check("drop_rdata", hs_rdata, model_mem[5]);
    check("drop_gnt_hold", hs_gnt, 1);
    check("drop_pause_hold", pause_req, 1);
    cpu_addr = 16'h0ABC; cpu_wdata = 8'h3C; cpu_we = 1'b0;
    cyc();
    check("drop_gnt_fall", hs_gnt, 0);
    check("drop_pause_fall", pause_req, 0);
    check("drop_cpu_addr", ram_addr, 16'h0ABC);
    check("drop_cpu_wdata", ram_wdata, 8'h3C);
    viol = 0;
    repeat (3) begin
      cyc();
      if (busy || pause_req || hs_gnt) viol++;
    end
    check("ack_stuck_ignored", viol, 0);

    // hs_req and pause_ack rising together in IDLE
    pause_ack = 1'b0;
    cyc();
    hs_req = 1'b1; pause_ack = 1'b1;
    measure_gnt(n);
    check("both_rise_latency", n, 7);

    // Release from GRANT without a strobe
    hs_req = 1'b0;
    cyc();
    check("rel_gnt_hold", hs_gnt, 1);
    cyc();
    check("rel_gnt_fall", hs_gnt, 0);
    check("rel_busy", busy, 0);

    // pause_ack drop during SETTLE restarts the wait
    pause_ack = 1'b0; hs_req = 1'b1;
    repeat (2) cyc();
    pause_ack = 1'b1;
    repeat (2) cyc();
    pause_ack = 1'b0;
    cyc();
    pause_ack = 1'b1;
    measure_gnt(n);
    check("settle_restart_latency", n, 6);
    hs_req = 1'b0; pause_ack = 1'b0;
    repeat (2) cyc();

    // Pause wait without acknowledge
    hs_req = 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
    n = 0;
    do begin
      cyc();
      n++;
    end while (!hs_abort && n < 300);
    check("abort_latency", n, 101);
    cyc();
    check("abort_pulse", hs_abort, 0);
    check("abort_pause_fall", pause_req, 0);
    pause_ack = 1'b1;
    viol = 0;
    repeat (20) begin
      cyc();
      if (pause_req || hs_gnt || busy) viol++;
    end
    check("abort_no_regrant", viol, 0);
    hs_req = 1'b0; pause_ack = 1'b0;
    cyc();
    hs_req = 1'b1; pause_ack = 1'b1;
    measure_gnt(n);
    check("abort_regrant_latency", n, 7);
    hs_req = 1'b0; pause_ack = 1'b0;
    repeat (2) cyc();
`else
    viol = 0;
    repeat (200) begin
      cyc();
      if (hs_abort || !pause_req || hs_gnt) viol++;
    end
    check("no_timeout_wait", viol, 0);
    hs_req = 1'b0;
    repeat (2) cyc();
    check("no_timeout_release", pause_req, 0);
`endif

    // Reset during a write access cancels the pending ram_we
    hs_req = 1'b1; pause_ack = 1'b1;
    measure_gnt(n);
    check("pre_reset_gnt", hs_gnt, 1);
    cpu_we = 1'b0; cpu_addr = 16'h0777; cpu_wdata = 8'h11;
    hs_stb = 1'b1; hs_we = 1'b1; hs_addr = 16'h0007; hs_wdata = ~model_mem[7];
    cyc();
    hs_stb = 1'b0;
    check("mid_rst_we_before", ram_we, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ram_we", ram_we, 0);
    check("mid_rst_gnt", hs_gnt, 0);
    check("mid_rst_ram_addr", ram_addr, 16'h0777);
    check("mid_rst_pause_req", pause_req, 0);
    cyc();
    check("mid_rst_no_write", mem[7], model_mem[7]);
    hs_req = 1'b0; pause_ack = 1'b0;
    reset = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
